// File: rtl/enc_pipe_if.sv
// Valid/ready bus for the SEC-DED encoder.
// Data words enter on IN, codewords leave on OUT.
interface enc_pipe_if;
    logic        IN_VALID;
    logic        IN_READY;
    logic [31:0] IN;
    logic        OUT_VALID;
    logic        OUT_READY;
    logic [38:0] OUT;

    modport master (
        output IN_VALID, IN, OUT_READY,
        input  IN_READY, OUT_VALID, OUT
    );

    modport slave (
        input  IN_VALID, IN, OUT_READY,
        output IN_READY, OUT_VALID, OUT
    );
endinterface

// File: rtl/enc_pipe.sv
// Two-stage Hsiao SEC-DED encoder: 32-bit data to {chk[6:0], data[31:0]}.
// Includes a one-shot XOR injection path to exercise the decoder in-system.
module enc_pipe #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    enc_pipe_if.slave        bus,
    input  logic             INJ_ARM,
    input  logic [38:0]      INJ_MASK,
    output logic             INJ_PEND,
    output logic [CNT_W-1:0] WCNT
);
    // Row i selects the data bits folded into check bit i.
    localparam logic [31:0] HM [7] = '{
        32'h2C0221FF,
        32'h13E5101F,
        32'hC06C89E1,
        32'h7D9C4422,
        32'hA2BBC244,
        32'h8B503E88,
        32'h5403FF10
    };

    function automatic logic [6:0] chk(input logic [31:0] d);
        logic [6:0] c;
        c = '0;
        for (int i = 0; i < 7; i++) c[i] = ^(d & HM[i]);
        return c;
    endfunction

    logic             s1_v;
    logic [31:0]      s1_d;
    logic             s1_f;
    logic [38:0]      s1_m;
    logic             s2_v;
    logic [38:0]      s2_q;
    logic             inj_pend;
    logic [38:0]      inj_mask;
    logic [CNT_W-1:0] wcnt;

    logic s2_free;
    logic s1_adv;
    logic acc;
    logic oxf;

    assign s2_free = ~s2_v | bus.OUT_READY;
    assign s1_adv  = s1_v & s2_free;
    assign bus.IN_READY = rst_n & (~s1_v | s2_free);
    assign acc = bus.IN_VALID & bus.IN_READY;
    assign oxf = s2_v & bus.OUT_READY;

    assign bus.OUT_VALID = s2_v;
    assign bus.OUT = s2_q;
    assign INJ_PEND = inj_pend;
    assign WCNT = wcnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v <= 1'b0;
            s1_d <= '0;
            s1_f <= 1'b0;
            s1_m <= '0;
        end else if (acc) begin
            s1_v <= 1'b1;
            s1_d <= bus.IN;
            s1_f <= inj_pend | INJ_ARM;
            s1_m <= inj_pend ? inj_mask : INJ_MASK;
        end else if (s1_adv) begin
            s1_v <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_v <= 1'b0;
            s2_q <= '0;
        end else if (s2_free) begin
            s2_v <= s1_v;
            if (s1_v) s2_q <= {chk(s1_d), s1_d} ^ (s1_f ? s1_m : 39'd0);
        end
    end

    // An arm coinciding with the consuming accept re-arms with the new mask.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inj_pend <= 1'b0;
            inj_mask <= '0;
        end else if (acc && inj_pend) begin
            inj_pend <= INJ_ARM;
            if (INJ_ARM) inj_mask <= INJ_MASK;
        end else if (INJ_ARM && !acc) begin
            inj_pend <= 1'b1;
            inj_mask <= INJ_MASK;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) wcnt <= '0;
        else if (oxf) wcnt <= wcnt + CNT_W'(1);
    end
endmodule

// File: doc/enc_pipe.md
# enc_pipe

Pipelined Hsiao SEC-DED encoder for the 32-bit data path. It takes 32-bit data words over a valid/ready handshake and emits 39-bit codewords, `{CHK[6:0], DATA[31:0]}`. Its parity equations make `dec_top` produce a zero syndrome on every unmodified codeword. It sits on the write/transmit side opposite `dec_top` and includes a one-shot error-injection port so the decoder path can be exercised in-system.

## Interface
- `CNT_W`, default 16, width of the delivered-word counter.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  reset; asynchronous and active-low.
- `IN_VALID`  in  1  data word offered.
- `IN_READY`  out  1  encoder can accept; a word transfers when `IN_VALID & IN_READY`.
- `IN`  in  32  data word.
- `OUT_VALID`  out  1  codeword available.
- `OUT_READY`  in  1  sink accepts; a word transfers when `OUT_VALID & OUT_READY`.
- `OUT`  out  39  codeword; `[31:0]` data, `[38:32]` check bits.
- `INJ_ARM`  in  1  single-cycle pulse; arms a one-shot injection.
- `INJ_MASK`  in  39  XOR mask; sampled when `INJ_ARM` is high.
- `INJ_PEND`  out  1  an armed injection has not yet been consumed.
- `WCNT`  out  `CNT_W`  number of codewords delivered; wraps modulo 2^`CNT_W`.

## Operation
- **Check bits:** each `CHK[i]` is the XOR of the listed data bits.
  - C0: 0,1,2,3,4,5,6,7,8,13,17,26,27,29
  - C1: 0,1,2,3,4,12,16,18,21,22,23,24,25,28
  - C2: 0,5,6,7,8,11,15,18,19,21,22,30,31
  - C3: 1,5,10,14,18,19,20,23,24,26,27,28,29,30
  - C4: 2,6,9,14,15,16,17,19,20,21,23,25,29,31
  - C5: 3,7,9,10,11,12,13,20,22,24,25,27,31
  - C6: 4,8,9,10,11,12,13,14,15,16,17,26,28,30
- **Stage 1 (S1):** registers the accepted data word, an injection flag and a 39-bit injection mask.
- **Stage 2 (S2):** registers `{CHK(S1 data), S1 data} ^ (flag ? mask : 0)`; `OUT` is driven directly from S2.
- **Flow control:**
  - S2 loads when `s2_free = ~S2_V | OUT_READY`.
  - S1 advances into S2 when `S1_V & s2_free`.
  - `IN_READY = rst_n & (~S1_V | s2_free)`. This is a combinational path from `OUT_READY` to `IN_READY`, and that path is permitted.
- **Injection register:** holds `inj_pend` and `inj_mask`.
  - `INJ_ARM` while `inj_pend=0` and no accept in that cycle: `inj_mask<=INJ_MASK`, `inj_pend<=1`.
  - Accept while `inj_pend=1`: the word is tagged with `inj_mask`. `inj_pend` clears, unless `INJ_ARM` is also high; then the new mask is captured and `inj_pend` stays 1.
  - `INJ_ARM` and accept in the same cycle while `inj_pend=0`: the word is tagged with `INJ_MASK` directly and `inj_pend` stays 0.
  - `INJ_ARM` while `inj_pend=1` and no accept: the mask is overwritten and `inj_pend` stays 1.
- **WCNT:** increments on every output transfer; `2^CNT_W-1` wraps to 0.
- **Order:** output order equals input order; no word is dropped or duplicated under any backpressure pattern.

## Timing
- **Reset state:** while `rst_n=0`, asynchronously:
  - `S1_V=0`, `S2_V=0`, `OUT_VALID=0`, `OUT=0`;
  - `inj_pend=0`, `INJ_PEND=0`, `inj_mask=0`;
  - `WCNT=0`, `IN_READY=0`.
- **After reset release:** `IN_READY=1` in the first cycle.
- **Latency:** a word accepted at edge N is presented with `OUT_VALID=1` after edge N+1. It is two register stages deep, so there are 2 cycles from the accept edge to the output-transfer opportunity.
- **Throughput:** one word per cycle when `OUT_READY=1` continuously.
- **Capacity:** with `OUT_READY=0`, at most 2 words are held (S1 and S2). After the second accept, `IN_READY=0` until `OUT_READY` rises.
- **Output stability:** while `OUT_VALID=1` and `OUT_READY=0`, `OUT` is held stable.
- **Simultaneous S2 output and S1 advance:** allowed in the same cycle.
- **Reset mid-operation:** in-flight words are discarded and the armed injection is cancelled.
- **`INJ_PEND` timing:** reflects `inj_pend` registered; it updates one edge after the arm or consume event.

## Test plan
- **Known vectors:**
  - `IN=32'h00000001` -> `OUT=39'h0700000001`
  - `IN=32'hFFFFFFFF` -> `OUT=39'h24FFFFFFFF`
  - `IN=0` -> `OUT=0`
  - Each appears 2 cycles after accept with `OUT_READY=1`.
- **Decoder loopback:** 10,000 random words feed `dec_top` -> `SYN=0`, `ERR=0`, and `OUT[31:0]` equals the input for every word.
- **Backpressure:**
  - Hold `OUT_READY=0` for 6 cycles with `IN_VALID=1` and words A,B,C -> A and B are accepted, `IN_READY=0`, `OUT=code(A)` is held stable.
  - Release `OUT_READY` -> A, B, C are delivered in order and `WCNT=3`.
- **Injection:**
  - `INJ_ARM` with `INJ_MASK=39'h1`, then send data 0 -> `OUT=39'h0000000001` and `INJ_PEND` clears.
  - The next word is clean.
  - `dec_top` reports `SGL=1` for the injected word.
  - Mask `39'h3` -> `DBL=1`.
- **Injection corner cases:**
  - Arm and accept in the same cycle with `inj_pend=0` -> that word is corrupted and `INJ_PEND` stays 0.
  - Re-arm while pending -> the last mask wins.
- **Reset and counter:**
  - Assert `rst_n` low with 2 words in flight -> `OUT_VALID=0`, `WCNT=0` immediately; no stale word appears after release.
  - With `CNT_W=4`, deliver 17 words -> `WCNT=1`.
